// File: rtl/decode_stage.sv
// RV32I decode stage: splits the instruction, reads operands with writeback forwarding, builds the immediate.
// Latency: one cycle from accepted input to out_valid; register file read addresses are combinational.
// Backpressure: valid/ready skid-free; a held bundle stalls fetch and keeps tracking writeback into its operands.
module decode_stage #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rf_read_reg1,
    output logic [4:0]  rf_read_reg2,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        illegal;
    } bundle_t;

    bundle_t     bundle_q, bundle_d;
    logic        valid_q, valid_d;
    logic        capture;
    logic [31:0] imm_dec;
    logic        legal_dec;
    logic [31:0] rs1_val_dec, rs2_val_dec;
    logic        upd_rs1, upd_rs2;

    assign rf_read_reg1 = in_instr[19:15];
    assign rf_read_reg2 = in_instr[24:20];
    assign in_ready     = !valid_q || out_ready || flush;
    assign capture      = in_valid && in_ready && !flush;

    // Immediate selection and legality check by opcode; illegal words carry a zero immediate.
    always_comb begin
        imm_dec   = '0;
        legal_dec = 1'b1;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm_dec = {{20{in_instr[31]}}, in_instr[31:20]};
            OP_STORE:
                imm_dec = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH:
                imm_dec = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_dec = {in_instr[31:12], 12'b0};
            OP_JAL:
                imm_dec = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            OP_REG, OP_FENCE:
                imm_dec = '0;
            default:
                legal_dec = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11) begin
            legal_dec = 1'b0;
        end
        if (!legal_dec) begin
            imm_dec = '0;
        end
    end

    // Operand capture: x0 reads as zero, a same-cycle writeback to the source wins over the register file.
    always_comb begin
        rs1_val_dec = rf_read_data1;
        rs2_val_dec = rf_read_data2;
        if (BYPASS && wb_regwrite && (wb_write_reg == rf_read_reg1)) begin
            rs1_val_dec = wb_write_data;
        end
        if (BYPASS && wb_regwrite && (wb_write_reg == rf_read_reg2)) begin
            rs2_val_dec = wb_write_data;
        end
        if (rf_read_reg1 == 5'd0) begin
            rs1_val_dec = '0;
        end
        if (rf_read_reg2 == 5'd0) begin
            rs2_val_dec = '0;
        end
    end

    // A stalled bundle must not go stale: writeback into one of its sources refreshes the held operand.
    assign upd_rs1 = BYPASS && valid_q && !capture && wb_regwrite &&
                     (wb_write_reg != 5'd0) && (wb_write_reg == bundle_q.rs1);
    assign upd_rs2 = BYPASS && valid_q && !capture && wb_regwrite &&
                     (wb_write_reg != 5'd0) && (wb_write_reg == bundle_q.rs2);

    // Next bundle and valid: flush beats capture, capture beats drain, otherwise hold.
    always_comb begin
        bundle_d = bundle_q;
        valid_d  = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            bundle_d.pc       = in_pc;
            bundle_d.rs1_val  = rs1_val_dec;
            bundle_d.rs2_val  = rs2_val_dec;
            bundle_d.imm      = imm_dec;
            bundle_d.rs1      = in_instr[19:15];
            bundle_d.rs2      = in_instr[24:20];
            bundle_d.rd       = in_instr[11:7];
            bundle_d.opcode   = in_instr[6:0];
            bundle_d.funct3   = in_instr[14:12];
            bundle_d.funct7b5 = in_instr[30];
            bundle_d.illegal  = !legal_dec;
        end else begin
            if (upd_rs1) begin
                bundle_d.rs1_val = wb_write_data;
            end
            if (upd_rs2) begin
                bundle_d.rs2_val = wb_write_data;
            end
        end
    end

    // Output register; reset clears the bundle immediately, independent of the clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = bundle_q.pc;
    assign out_rs1_val  = bundle_q.rs1_val;
    assign out_rs2_val  = bundle_q.rs2_val;
    assign out_imm      = bundle_q.imm;
    assign out_rs1      = bundle_q.rs1;
    assign out_rs2      = bundle_q.rs2;
    assign out_rd       = bundle_q.rd;
    assign out_opcode   = bundle_q.opcode;
    assign out_funct3   = bundle_q.funct3;
    assign out_funct7b5 = bundle_q.funct7b5;
    assign out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances share stimulus, one with forwarding and one without.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-decoded from the instruction encodings.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_regwrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_funct7b5, out_illegal;
    logic [4:0]  rf_read_reg1, rf_read_reg2, out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;

    logic        nb_in_ready, nb_out_valid, nb_out_funct7b5, nb_out_illegal;
    logic [4:0]  nb_rf_read_reg1, nb_rf_read_reg2, nb_out_rs1, nb_out_rs2, nb_out_rd;
    logic [31:0] nb_out_pc, nb_out_rs1_val, nb_out_rs2_val, nb_out_imm;
    logic [6:0]  nb_out_opcode;
    logic [2:0]  nb_out_funct3;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
    );

    decode_stage #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(nb_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_read_reg1(nb_rf_read_reg1), .rf_read_reg2(nb_rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .flush(flush), .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_pc(nb_out_pc), .out_rs1_val(nb_out_rs1_val), .out_rs2_val(nb_out_rs2_val),
        .out_imm(nb_out_imm),
        .out_rs1(nb_out_rs1), .out_rs2(nb_out_rs2), .out_rd(nb_out_rd),
        .out_opcode(nb_out_opcode), .out_funct3(nb_out_funct3),
        .out_funct7b5(nb_out_funct7b5), .out_illegal(nb_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        rf_read_data1 = 32'h0; rf_read_data2 = 32'h0;
        wb_regwrite = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'h0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_imm", out_imm, 32'h0);
        reset = 1'b1;

        // Combinational read addresses, independent of in_valid (add x3,x1,x2)
        in_instr = 32'h002081B3;
        #1;
        check("rf_reg1", {27'b0, rf_read_reg1}, 32'd1);
        check("rf_reg2", {27'b0, rf_read_reg2}, 32'd2);

        // addi x1,x0,5 at 0x100; rs1 is x0 so rf data must be ignored
        rf_read_data1 = 32'hDEAD_BEEF;
        present(32'h00500093, 32'h100);
        tick();
        check("addi_valid", {31'b0, out_valid}, 32'h1);
        check("addi_rd", {27'b0, out_rd}, 32'd1);
        check("addi_imm", out_imm, 32'd5);
        check("addi_rs1v", out_rs1_val, 32'h0);
        check("addi_pc", out_pc, 32'h100);
        check("addi_opc", {25'b0, out_opcode}, 32'h13);

        // add x3,x1,x2 with writeback to x2 in the same cycle
        present(32'h002081B3, 32'h104);
        rf_read_data1 = 32'd7; rf_read_data2 = 32'd9;
        wb_regwrite = 1'b1; wb_write_reg = 5'd2; wb_write_data = 32'h55;
        tick();
        wb_regwrite = 1'b0;
        check("add_rs1v", out_rs1_val, 32'd7);
        check("add_rs2v_byp", out_rs2_val, 32'h55);
        check("add_rs2v_nobyp", nb_out_rs2_val, 32'd9);
        check("add_rd", {27'b0, out_rd}, 32'd3);
        check("add_imm", out_imm, 32'h0);
        check("add_ill", {31'b0, out_illegal}, 32'h0);

        // addi x6,x5,1 at 0x108, then stall three cycles with x5 written in cycle 2
        present(32'h00128313, 32'h108);
        rf_read_data1 = 32'h11;
        tick();
        check("stl_cap_rs1v", out_rs1_val, 32'h11);
        check("stl_cap_rs1", {27'b0, out_rs1}, 32'd5);
        out_ready = 1'b0;
        present(32'hFE000EE3, 32'h10C);
        rf_read_data1 = 32'h77; rf_read_data2 = 32'h66;
        #1;
        check("stl_rdy0", {31'b0, in_ready}, 32'h0);
        tick();
        check("stl_c1_rdy", {31'b0, in_ready}, 32'h0);
        check("stl_c1_pc", out_pc, 32'h108);
        wb_regwrite = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'hAB;
        tick();
        wb_regwrite = 1'b0;
        check("stl_c2_rdy", {31'b0, in_ready}, 32'h0);
        check("stl_c2_rs1v", out_rs1_val, 32'hAB);
        check("stl_c2_nobyp", nb_out_rs1_val, 32'h11);
        tick();
        check("stl_c3_valid", {31'b0, out_valid}, 32'h1);
        check("stl_c3_pc", out_pc, 32'h108);
        check("stl_c3_rs1v", out_rs1_val, 32'hAB);
        out_ready = 1'b1;
        #1;
        check("stl_rel_rdy", {31'b0, in_ready}, 32'h1);
        tick();
        // beq x0,x0,-4 replaces the drained bundle with no bubble
        check("beq_valid", {31'b0, out_valid}, 32'h1);
        check("beq_pc", out_pc, 32'h10C);
        check("beq_imm", out_imm, 32'hFFFF_FFFC);
        check("beq_rs1v_x0", out_rs1_val, 32'h0);

        // Remaining immediate formats and illegal encodings
        present(32'h800000EF, 32'h110);
        tick();
        check("jal_imm", out_imm, 32'hFFF0_0000);
        check("jal_rd", {27'b0, out_rd}, 32'd1);
        present(32'h123450B7, 32'h114);
        tick();
        check("lui_imm", out_imm, 32'h1234_5000);
        present(32'hFE20AC23, 32'h118);
        tick();
        check("sw_imm", out_imm, 32'hFFFF_FFF8);
        check("sw_f3", {29'b0, out_funct3}, 32'd2);
        present(32'h0000007F, 32'h11C);
        tick();
        check("ill_flag", {31'b0, out_illegal}, 32'h1);
        check("ill_imm", out_imm, 32'h0);
        check("ill_valid", {31'b0, out_valid}, 32'h1);
        present(32'h00500090, 32'h120);
        tick();
        check("ill_lowbits", {31'b0, out_illegal}, 32'h1);
        present(32'h40208033, 32'h124);
        tick();
        check("sub_f7b5", {31'b0, out_funct7b5}, 32'h1);

        // Drain with no new input
        in_valid = 1'b0;
        tick();
        check("drain_valid", {31'b0, out_valid}, 32'h0);

        // Flush with in_valid during a stall drops both held and incoming
        present(32'h00500093, 32'h200);
        tick();
        out_ready = 1'b0;
        present(32'h002081B3, 32'h204);
        flush = 1'b1;
        #1;
        check("fl_rdy", {31'b0, in_ready}, 32'h1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", {31'b0, out_valid}, 32'h0);
        tick();
        check("fl_valid2", {31'b0, out_valid}, 32'h0);

        // Reset mid-stall clears immediately, without a clock edge
        present(32'h00500093, 32'h300);
        tick();
        in_valid = 1'b0;
        tick();
        check("rs_held", {31'b0, out_valid}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("rs_async_valid", {31'b0, out_valid}, 32'h0);
        check("rs_async_pc", out_pc, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("rs_post_idle", {31'b0, out_valid}, 32'h0);
        present(32'h00500093, 32'h304);
        tick();
        check("rs_post_cap", {31'b0, out_valid}, 32'h1);
        check("rs_post_pc", out_pc, 32'h304);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
